muldiv_unit: RTL

Parametrised multi-cycle multiply/divide engine for the execute stage. It replaces the single-width ALU-embedded divider and its fixed stall.
- Produces a 2*WIDTH hi/lo result for signed and unsigned mult and div.
- Raises a stall toward the hazard unit while busy.
- Aborts cleanly on an execute-stage flush.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_unit_div_iter.sv | 34 +++
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Operation and state encodings shared by the mul/div engine.
// Revision    : 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/result bundle between execute stage and mul/div engine.
// Revision    : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : One combinational restoring-division step on magnitudes.
// Revision    : 1.0
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  wire  [WIDTH-1:0] i_rem,
    input  wire  [WIDTH-1:0] i_quo,
    input  wire  [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The dividend is shifted out of the quotient register MSB-first.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_div};
        if (!w_diff[WIDTH]) begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle signed/unsigned multiply/divide with stall/flush.
//               Optional macro MULDIV_EARLY_OUT_EN: trivial divides skip DIV.
// Revision    : 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input wire      clk,
    input wire      rst,
    muldiv_if.slave bus
);

    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_is_mul;
    logic               r_div_zero;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_valid;
    logic               w_accept;
    logic               w_busy;
    logic               w_done;
    logic               w_op_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_nrem;
    logic [WIDTH-1:0]   w_nquo;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_valid     = op_is_valid(bus.op);
    assign w_accept    = !rst && !bus.flush && (r_state == S_IDLE) && bus.start && w_valid;
    assign w_busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_op_signed = op_is_signed(bus.op);
    assign w_a_neg     = w_op_signed && bus.a[WIDTH-1];
    assign w_b_neg     = w_op_signed && bus.b[WIDTH-1];
    assign w_abs_a     = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b     = w_b_neg ? -bus.b : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
    logic w_early;
    assign w_early = (bus.b == '0) || (w_abs_a < w_abs_b);
`endif

    // Sign-extending to 2*WIDTH makes the low half of an unsigned product the
    // correct two's-complement result, so one multiplier serves both modes.
    assign w_mul_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_mul_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_mul_a * w_mul_b;

    generate
        if (MUL_STAGES > 1) begin : g_mul_pipe
            logic [2*WIDTH-1:0] r_pipe [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                r_pipe[0] <= w_prod;
                for (int i = 1; i < MUL_STAGES - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_mul_res = r_pipe[MUL_STAGES-2];
        end else begin : g_mul_comb
            assign w_mul_res = w_prod;
        end
    endgenerate

    div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_dvs),
        .o_rem (w_nrem),
        .o_quo (w_nquo)
    );

    assign w_q_fix  = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix  = r_r_neg ? -r_rem : r_rem;
    assign w_res_hi = r_is_mul   ? w_mul_res[2*WIDTH-1:WIDTH] :
                      r_div_zero ? r_a : w_r_fix;
    assign w_res_lo = r_is_mul   ? w_mul_res[WIDTH-1:0] :
                      r_div_zero ? {WIDTH{1'b1}} : w_q_fix;

    // The result is presented during FIX and only committed if not flushed,
    // so a flush in the done cycle leaves hi/lo untouched.
    assign w_done    = !rst && !bus.flush && (r_state == S_FIX);
    assign bus.done  = w_done;
    assign bus.stall = w_accept || (!rst && !bus.flush && w_busy);
    assign bus.hi    = w_done ? w_res_hi : r_hi;
    assign bus.lo    = w_done ? w_res_lo : r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_is_mul   <= 1'b0;
            r_div_zero <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_signed   <= w_op_signed;
                        r_is_mul   <= op_is_mul(bus.op);
                        r_div_zero <= (bus.b == '0);
                        r_q_neg    <= w_a_neg ^ w_b_neg;
                        r_r_neg    <= w_a_neg;
                        r_rem      <= '0;
                        r_quo      <= w_abs_a;
                        r_dvs      <= w_abs_b;
                        if (op_is_mul(bus.op)) begin
                            r_cnt   <= c_mul_cnt;
                            r_state <= (MUL_STAGES > 1) ? S_MUL : S_FIX;
                        end else begin
                            r_cnt   <= c_div_cnt;
                            r_state <= S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
                            if (w_early) begin
                                // Quotient 0, remainder |a|: FIX restores a's sign.
                                r_rem   <= w_abs_a;
                                r_quo   <= '0;
                                r_state <= S_FIX;
                            end
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    r_rem <= w_nrem;
                    r_quo <= w_nquo;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
